// File: rtl/ocupacao_pkg.sv
// Shared definitions for the occupancy detector chain: FSM state encoding
// and default timing constants for a 50 MHz system clock.
package ocupacao_pkg;

  typedef enum logic [1:0] {
    LIVRE    = 2'b00,
    CONFIRMA = 2'b01,
    OCUPADO  = 2'b10,
    ESPERA   = 2'b11
  } estado_t;

  localparam int CLK_HZ          = 50000000;
  // 20 ms of debounce and 5 s of hold time at CLK_HZ
  localparam int DEBOUNCE_PADRAO = CLK_HZ / 50;
  localparam int ESPERA_PADRAO   = CLK_HZ * 5;

endpackage

// File: rtl/sincronizador_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs; both stages reset to 0.
module sincronizador_2ff #(
  parameter int LARGURA = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LARGURA-1:0] i_async,
  output logic [LARGURA-1:0] o_sync
);

  logic [LARGURA-1:0] r_s1;
  logic [LARGURA-1:0] r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
    end
  end

  assign o_sync = r_s2;

endmodule

// File: rtl/detector_ocupacao.sv
// PIR occupancy detector: synchronise, debounce rising activity, hold for a timeout.
// Optional entry counter enabled by defining DETECTOR_CONTADOR_EN.
module detector_ocupacao
  import ocupacao_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS     = DEBOUNCE_PADRAO,
  parameter int TEMPO_ESPERA_CICLOS = ESPERA_PADRAO
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sensor_pir,
  output logic        ocupado,
  output logic        pulso_entrada,
  output logic        pulso_saida
`ifdef DETECTOR_CONTADOR_EN
  ,
  output logic [15:0] num_entradas
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CICLOS);
  localparam int TW = $clog2(TEMPO_ESPERA_CICLOS);
  localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CICLOS - 1);
  localparam logic [TW-1:0] TMR_FIM = TW'(TEMPO_ESPERA_CICLOS - 1);

  logic          w_s2;
  estado_t       r_estado, w_estado_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [TW-1:0] r_tmr, w_tmr_next;
  logic          r_ocupado, w_ocupado_next;
  logic          r_pulso_entrada, w_pulso_entrada_next;
  logic          r_pulso_saida, w_pulso_saida_next;

  sincronizador_2ff #(.LARGURA(1)) u_sinc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (sensor_pir),
    .o_sync  (w_s2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado        <= LIVRE;
      r_cnt           <= '0;
      r_tmr           <= '0;
      r_ocupado       <= 1'b0;
      r_pulso_entrada <= 1'b0;
      r_pulso_saida   <= 1'b0;
    end else begin
      r_estado        <= w_estado_next;
      r_cnt           <= w_cnt_next;
      r_tmr           <= w_tmr_next;
      r_ocupado       <= w_ocupado_next;
      r_pulso_entrada <= w_pulso_entrada_next;
      r_pulso_saida   <= w_pulso_saida_next;
    end
  end

  always_comb begin
    w_estado_next        = r_estado;
    w_cnt_next           = r_cnt;
    w_tmr_next           = r_tmr;
    w_pulso_entrada_next = 1'b0;
    w_pulso_saida_next   = 1'b0;
    case (r_estado)
      LIVRE: begin
        if (w_s2) begin
          w_estado_next = CONFIRMA;
          w_cnt_next    = CW'(1);
        end
      end
      CONFIRMA: begin
        // a low sample always wins, even on the terminal count
        if (!w_s2) begin
          w_estado_next = LIVRE;
          w_cnt_next    = '0;
        end else if (r_cnt == CNT_FIM) begin
          w_estado_next        = OCUPADO;
          w_pulso_entrada_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      OCUPADO: begin
        if (!w_s2) begin
          w_estado_next = ESPERA;
          w_tmr_next    = '0;
        end
      end
      ESPERA: begin
        // retrigger beats the terminal timer and skips the debounce
        if (w_s2) begin
          w_estado_next = OCUPADO;
          w_tmr_next    = '0;
        end else if (r_tmr == TMR_FIM) begin
          w_estado_next      = LIVRE;
          w_pulso_saida_next = 1'b1;
        end else begin
          w_tmr_next = r_tmr + TW'(1);
        end
      end
      default: w_estado_next = LIVRE;
    endcase
    w_ocupado_next = (w_estado_next == OCUPADO) || (w_estado_next == ESPERA);
  end

  assign ocupado       = r_ocupado;
  assign pulso_entrada = r_pulso_entrada;
  assign pulso_saida   = r_pulso_saida;

`ifdef DETECTOR_CONTADOR_EN
  logic [15:0] r_num_entradas;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num_entradas <= '0;
    end else if (w_pulso_entrada_next && (r_num_entradas != 16'hFFFF)) begin
      r_num_entradas <= r_num_entradas + 16'd1;
    end
  end

  assign num_entradas = r_num_entradas;
`endif

endmodule

// File: tb/tb_detector_ocupacao.sv
// Self-checking bench for detector_ocupacao with short debounce/hold times.
// The LED stage downstream is modelled here as led_r = ocupado, led_g = !ocupado.
module tb_detector_ocupacao;

  localparam int DEB = 4;
  localparam int TMP = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sensor_pir = 1'b0;
  logic ocupado, pulso_entrada, pulso_saida;
`ifdef DETECTOR_CONTADOR_EN
  logic [15:0] num_entradas;
`endif
  logic led_r, led_g;

  assign led_r = ocupado;
  assign led_g = ~ocupado;

  always #5 clk = ~clk;

  detector_ocupacao #(
    .DEBOUNCE_CICLOS     (DEB),
    .TEMPO_ESPERA_CICLOS (TMP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sensor_pir    (sensor_pir),
    .ocupado       (ocupado),
    .pulso_entrada (pulso_entrada),
    .pulso_saida   (pulso_saida)
`ifdef DETECTOR_CONTADOR_EN
    ,
    .num_entradas  (num_entradas)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;

  // behavioural model: sensor history, run lengths of high/low samples
  logic [1:0] m_hist;
  int m_run, m_idle, m_num;
  logic m_occ, m_pin, m_pout;
  int seg_pin, seg_pout;

  typedef struct {
    logic nivel;
    int   ciclos;
    logic exp_ocup;
    int   exp_pin;
    int   exp_pout;
  } seg_t;

  seg_t tab[11];

  task automatic chk(input string nome, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nome, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist = 2'b00;
    m_run  = 0;
    m_idle = 0;
    m_num  = 0;
    m_occ  = 1'b0;
    m_pin  = 1'b0;
    m_pout = 1'b0;
  endtask

  task automatic tick(input logic s);
    logic samp;
    sensor_pir = s;
    @(posedge clk);
    samp   = m_hist[1];
    m_hist = {m_hist[0], s};
    m_pin  = 1'b0;
    m_pout = 1'b0;
    if (!m_occ) begin
      m_run = samp ? m_run + 1 : 0;
      if (m_run == DEB) begin
        m_occ = 1'b1; m_pin = 1'b1; m_run = 0; m_idle = 0;
        if (m_num != 65535) m_num++;
      end
    end else begin
      m_idle = samp ? 0 : m_idle + 1;
      if (m_idle == TMP + 1) begin
        m_occ = 1'b0; m_pout = 1'b1; m_idle = 0; m_run = 0;
      end
    end
    #1;
    chk("model_ocupado", int'(ocupado), int'(m_occ));
    chk("model_pulsos", int'({pulso_entrada, pulso_saida}), int'({m_pin, m_pout}));
`ifdef DETECTOR_CONTADOR_EN
    chk("model_num_entradas", int'(num_entradas), m_num);
`endif
    seg_pin  += int'(pulso_entrada);
    seg_pout += int'(pulso_saida);
  endtask

  task automatic reset_check();
    #1;
    chk("reset_ocupado", int'(ocupado), 0);
    chk("reset_pulsos", int'({pulso_entrada, pulso_saida}), 0);
`ifdef DETECTOR_CONTADOR_EN
    chk("reset_num_entradas", int'(num_entradas), 0);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    reset_check();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic sempre;
    tab[0]  = '{1'b0, 3,  1'b0, 0, 0};
    tab[1]  = '{1'b1, 10, 1'b1, 1, 0};  // clean entry, rises on 6th edge
    tab[2]  = '{1'b0, 22, 1'b1, 0, 0};  // still held after 22 low edges
    tab[3]  = '{1'b0, 1,  1'b0, 0, 1};  // released on 23rd low edge
    tab[4]  = '{1'b0, 5,  1'b0, 0, 0};
    tab[5]  = '{1'b1, 3,  1'b0, 0, 0};  // 3-cycle glitch
    tab[6]  = '{1'b0, 6,  1'b0, 0, 0};
    tab[7]  = '{1'b1, 4,  1'b0, 0, 0};  // minimal 4-cycle pulse
    tab[8]  = '{1'b0, 3,  1'b1, 1, 0};
    tab[9]  = '{1'b0, 19, 1'b1, 0, 0};
    tab[10] = '{1'b0, 1,  1'b0, 0, 1};

    // reset held with sensor high
    sensor_pir = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    reset_check();
    model_reset();
    rst_n = 1'b1;
    repeat (5) tick(1'b1);
    chk("reset_no_occ_before_6", int'(ocupado), 0);
    tick(1'b1);
    chk("reset_occ_after_6", int'(ocupado), 1);
    repeat (30) tick(1'b0);
    chk("idle_after_reset_seq", int'(ocupado), 0);

    foreach (tab[i]) begin
      seg_pin  = 0;
      seg_pout = 0;
      repeat (tab[i].ciclos) tick(tab[i].nivel);
      $display("seg %0d: sensor=%0d cycles=%0d ocupado=%0d entries=%0d exits=%0d",
               i, tab[i].nivel, tab[i].ciclos, ocupado, seg_pin, seg_pout);
      chk($sformatf("tab%0d_ocupado", i), int'(ocupado), int'(tab[i].exp_ocup));
      chk($sformatf("tab%0d_led_r", i), int'(led_r), int'(tab[i].exp_ocup));
      chk($sformatf("tab%0d_led_g", i), int'(led_g), int'(!tab[i].exp_ocup));
      chk($sformatf("tab%0d_pin", i), seg_pin, tab[i].exp_pin);
      chk($sformatf("tab%0d_pout", i), seg_pout, tab[i].exp_pout);
    end

    // rise and fall latency
    n = 0;
    do begin tick(1'b1); n++; end while (!ocupado && n < 50);
    chk("lat_rise_edges", n, 6);
    repeat (2) tick(1'b1);
    n = 0;
    do begin tick(1'b0); n++; end while (ocupado && n < 100);
    chk("lat_fall_edges", n, 23);

    // retrigger while tmr is 10
    repeat (3) tick(1'b0);
    repeat (8) tick(1'b1);
    chk("retrig_entered", int'(ocupado), 1);
    seg_pin = 0; seg_pout = 0; sempre = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick(i < 11 ? 1'b0 : 1'b1);
      sempre &= ocupado;
    end
    chk("retrig_held", int'(sempre), 1);
    chk("retrig_no_entry", seg_pin, 0);
    n = 0;
    do begin tick(1'b0); n++; end while (ocupado && n < 100);
    chk("retrig_full_release", n, 23);
    chk("retrig_exit_pulses", seg_pout, 1);
    $display("retrigger: release after %0d edges, entries=%0d exits=%0d", n, seg_pin, seg_pout);

    // terminal timer coincides with high sample: retrigger wins
    repeat (3) tick(1'b0);
    repeat (8) tick(1'b1);
    seg_pout = 0; sempre = 1'b1;
    for (int i = 0; i < 26; i++) begin
      tick(i < 20 ? 1'b0 : 1'b1);
      sempre &= ocupado;
    end
    chk("terminal_retrig_held", int'(sempre), 1);
    chk("terminal_retrig_no_exit", seg_pout, 0);

    // three entries, then async reset during ESPERA
    sensor_pir = 1'b0;
    do_reset();
    for (int e = 0; e < 3; e++) begin
      repeat (6) tick(1'b1);
      repeat (25) tick(1'b0);
    end
`ifdef DETECTOR_CONTADOR_EN
    chk("three_entries_count", int'(num_entradas), 3);
    $display("counter after 3 entries: %0d", num_entradas);
`endif
    repeat (6) tick(1'b1);
    repeat (5) tick(1'b0);
    chk("espera_before_reset", int'(ocupado), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_ocupado", int'(ocupado), 0);
`ifdef DETECTOR_CONTADOR_EN
    chk("async_reset_num", int'(num_entradas), 0);
`endif
    $display("async reset in ESPERA: ocupado=%0d", ocupado);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) tick(1'b0);

    // randomized segments against the model
    for (int s = 0; s < 40; s++) begin
      logic lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 28);
      seg_pin = 0; seg_pout = 0;
      repeat (len) tick(lvl);
      $display("rand %0d: sensor=%0d cycles=%0d ocupado=%0d entries=%0d exits=%0d",
               s, lvl, len, ocupado, seg_pin, seg_pout);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
